// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared pipeline definitions for the writeback stage: result-select
// encodings driven by decode (super_sel) and the link register index used by
// jal. Imported by the writeback stage and its neighbours.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int SEL_W = 3;

    // Result-select encodings; values 5-7 are unused and produce zero.
    typedef enum logic [SEL_W-1:0] {
        SEL_ALU   = 3'd0,
        SEL_SHIFT = 3'd1,
        SEL_HI    = 3'd2,
        SEL_LO    = 3'd3,
        SEL_PC4   = 3'd4
    } super_sel_e;

    // Link register written by jal.
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundle between the MEM/WB pipeline register and the writeback stage, plus
// the register-file write port the stage drives.
//   master : MEM/WB side; drives the W-stage fields, observes the rf write.
//   slave  : writeback stage; consumes the W-stage fields, drives the rf write.
// W-stage fields: valid_w, multu_enW, jr_selW, super_selW, dm2regW, jumpW,
//   jal_selW, we_regW, pc_plus_4W, alu_outW (64b), rd_dmW, shiftyW, rf_waW.
// rf write port : rf_we, rf_wa, rf_wd.
// -----------------------------------------------------------------------------
interface wb_stage_if;

    logic                           valid_w;
    logic                           multu_enW;
    logic                           jr_selW;
    logic [wb_stage_pkg::SEL_W-1:0] super_selW;
    logic                           dm2regW;
    logic                           jumpW;
    logic                           jal_selW;
    logic                           we_regW;
    logic [31:0]                    pc_plus_4W;
    logic [63:0]                    alu_outW;
    logic [31:0]                    rd_dmW;
    logic [31:0]                    shiftyW;
    logic [4:0]                     rf_waW;

    logic                           rf_we;
    logic [4:0]                     rf_wa;
    logic [31:0]                    rf_wd;

    modport master (
        output valid_w, multu_enW, jr_selW, super_selW, dm2regW, jumpW,
               jal_selW, we_regW, pc_plus_4W, alu_outW, rd_dmW, shiftyW,
               rf_waW,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  valid_w, multu_enW, jr_selW, super_selW, dm2regW, jumpW,
               jal_selW, we_regW, pc_plus_4W, alu_outW, rd_dmW, shiftyW,
               rf_waW,
        output rf_we, rf_wa, rf_wd
    );

endinterface

// File: rtl/wb_stage_hilo_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_hilo_reg
// Architectural HI/LO register pair with load enable, asynchronous reset and
// a same-cycle bypass so consumers in earlier stages see a multu result in
// the cycle it retires.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              load HI/LO from din this cycle
//   din[63:0]       {HI, LO} product
//   hi_q, lo_q      registered HI/LO
//   hi_fwd, lo_fwd  din halves when en, else the registered values
// -----------------------------------------------------------------------------
module wb_stage_hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [63:0] din,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic [31:0] hi_fwd,
    output logic [31:0] lo_fwd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (en) begin
            hi_q <= din[63:32];
            lo_q <= din[31:0];
        end
    end

    assign hi_fwd = en ? din[63:32] : hi_q;
    assign lo_fwd = en ? din[31:0]  : lo_q;

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage. Consumes the W-side outputs of the MEM/WB register and
//   - forms the register-file write enable / address / data,
//   - owns the architectural HI/LO registers (with same-cycle bypass),
//   - keeps a one-entry history of the last cycle's writeback for late
//     forwarding in the hazard unit,
//   - counts retired (valid) instructions.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   w (slave)           W-stage fields in, register-file write port out
//   hi_q, lo_q          architectural HI/LO
//   hi_fwd, lo_fwd      HI/LO with same-cycle multu bypass
//   prev_we/wa/wd       previous cycle's rf_we/rf_wa/rf_wd
//   retired             retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int RA_IDX = 31,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_if.slave        w,
    output logic [31:0]      hi_q,
    output logic [31:0]      lo_q,
    output logic [31:0]      hi_fwd,
    output logic [31:0]      lo_fwd,
    output logic             prev_we,
    output logic [4:0]       prev_wa,
    output logic [31:0]      prev_wd,
    output logic [CNT_W-1:0] retired
);

    localparam logic [4:0] RA_ADDR = RA_IDX[4:0];

    logic        hilo_en;
    logic        rf_we_c;
    logic [4:0]  rf_wa_c;
    logic [31:0] sel_data;
    logic [31:0] rf_wd_c;

    assign hilo_en = w.valid_w & w.multu_enW;

    wb_stage_hilo_reg u_hilo (
        .clk    (clk),
        .rst    (rst),
        .en     (hilo_en),
        .din    (w.alu_outW),
        .hi_q   (hi_q),
        .lo_q   (lo_q),
        .hi_fwd (hi_fwd),
        .lo_fwd (lo_fwd)
    );

    // jal writes the link register even though jumpW is set; a plain j/jr
    // never writes. $0 is hard-wired, so any write aimed at it is dropped.
    assign rf_wa_c = w.jal_selW ? RA_ADDR : w.rf_waW;
    assign rf_we_c = w.valid_w & ~w.jr_selW
                   & (w.jal_selW | (w.we_regW & ~w.jumpW))
                   & (rf_wa_c != 5'd0);

    // HI/LO selects use the registered values: an mfhi/mflo directly behind
    // a multu already sees the new value since the multu retired last cycle.
    always_comb begin
        sel_data = '0;
        case (w.super_selW)
            SEL_ALU:   sel_data = w.alu_outW[31:0];
            SEL_SHIFT: sel_data = w.shiftyW;
            SEL_HI:    sel_data = hi_q;
            SEL_LO:    sel_data = lo_q;
            SEL_PC4:   sel_data = w.pc_plus_4W;
            default:   sel_data = '0;
        endcase
    end

    always_comb begin
        rf_wd_c = sel_data;
        if (w.jal_selW) begin
            rf_wd_c = w.pc_plus_4W;
        end else if (w.dm2regW) begin
            rf_wd_c = w.rd_dmW;
        end
    end

    assign w.rf_we = rf_we_c;
    assign w.rf_wa = rf_wa_c;
    assign w.rf_wd = rf_wd_c;

    // History register and retirement counter. The history records every
    // cycle, bubbles included, so prev_we drops to 0 behind a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_we <= 1'b0;
            prev_wa <= '0;
            prev_wd <= '0;
            retired <= '0;
        end else begin
            prev_we <= rf_we_c;
            prev_wa <= rf_wa_c;
            prev_wd <= rf_wd_c;
            if (w.valid_w) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage; consumes the W-side outputs of the MEM/WB pipeline register.
- Selects the register-file write data and address.
- Owns the architectural HI/LO registers.
- Keeps a one-entry writeback history register for late forwarding.
- Counts retired instructions.
Sits between the MEM/WB pipeline register and the register file / hazard unit.

Parameters:
RA_IDX, 31, register index written by jal
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
valid_w  input  1  W-stage holds a real instruction (0 = bubble)
multu_enW  input  1  multu result writes HI/LO
jr_selW  input  1  jr instruction; suppresses rf write
super_selW  input  3  result select: 0 alu_lo, 1 shifty, 2 HI, 3 LO, 4 pc_plus_4; 5-7 give 0
dm2regW  input  1  load; rd_dm is the result
jumpW  input  1  j/jal; rf write only when jal_selW
jal_selW  input  1  jal; write pc_plus_4 to RA_IDX
we_regW  input  1  register write enable from decode
pc_plus_4W  input  32  return address
alu_outW  input  64  ALU result; full 64 bits for multu
rd_dmW  input  32  load data
shiftyW  input  32  shifter result
rf_waW  input  5  destination register
rf_we  output  1  register-file write enable
rf_wa  output  5  register-file write address
rf_wd  output  32  register-file write data
hi_q  output  32  architectural HI
lo_q  output  32  architectural LO
hi_fwd  output  32  HI with same-cycle multu bypass
lo_fwd  output  32  LO with same-cycle multu bypass
prev_we  output  1  previous-cycle writeback valid
prev_wa  output  5  previous-cycle write address
prev_wd  output  32  previous-cycle write data
retired  output  CNT_W  retired instruction count

Behaviour:
- Reset is asynchronous on rst high. It clears hi_q, lo_q, prev_we, prev_wa, prev_wd and retired to 0. Combinational outputs follow the inputs during reset.
- Write enable: rf_we = valid_w & ~jr_selW & (jal_selW | (we_regW & ~jumpW)) & (rf_wa != 0). Writes to $0 are always suppressed.
- Write address: rf_wa = jal_selW ? RA_IDX : rf_waW.
- Write data priority, highest first: jal_selW -> pc_plus_4W; dm2regW -> rd_dmW; otherwise select by super_selW.
  - super_sel 0 = alu_outW[31:0]; 1 = shiftyW; 2 = hi_q; 3 = lo_q; 4 = pc_plus_4W; 5-7 = 32'h0.
  - HI/LO selects read the registered value, not the bypassed value.
- HI/LO update: on posedge clk, if valid_w & multu_enW, hi_q <= alu_outW[63:32] and lo_q <= alu_outW[31:0]. Otherwise both hold.
  - multu does not write the register file unless we_regW is also set; rf_we follows the formula regardless.
- Bypass: hi_fwd = (valid_w & multu_enW) ? alu_outW[63:32] : hi_q. lo_fwd is the same using alu_outW[31:0]. Purely combinational.
- History register: on every posedge, prev_we <= rf_we, prev_wa <= rf_wa, prev_wd <= rf_wd. It always records the last cycle, bubbles included (prev_we = 0 then). Latency is exactly 1 cycle.
- Counter: on posedge, if valid_w then retired <= retired + 1. Wraps modulo 2^CNT_W with no saturation.
- Bubbles (valid_w = 0): no rf write, no HI/LO change, no count.
- Reset mid-stream: all state clears immediately. The first post-reset valid instruction is counted as 1.
- A multu followed directly by mfhi in W sees the new HI: by then it is registered in hi_q.

Decomposition:
- Shared package (pipeline defines file): SUPER_SEL encodings (SEL_ALU, SEL_SHIFT, SEL_HI, SEL_LO, SEL_PC4) and REG_RA = 31.
- One natural sub-module, hilo_reg: 64-bit HI/LO storage with enable and async reset, plus the bypass mux.
- The result mux and counter stay inline.

Test Plan:
- Reset: assert rst mid-cycle with hi_q = 5 and retired = 7 -> all registered outputs 0 immediately, asynchronously.
- ALU write: valid_w = 1, we_regW = 1, rf_waW = 8, super_sel = 0, alu_out = 64'h0_0000002A -> rf_we = 1, wa = 8, wd = 0x2A; next cycle prev_wd = 0x2A, retired += 1.
- Load vs select priority: dm2regW = 1, super_sel = 1, rd_dm = 0xDEADBEEF, shifty = 0x1 -> wd = 0xDEADBEEF.
- jal: jal_selW = 1, jumpW = 1, we_regW = 0, pc_plus_4 = 0x40 -> rf_we = 1, wa = 31, wd = 0x40. jr with we_regW = 1 -> rf_we = 0.
- multu: alu_out = 64'h00000003_00000004, multu_en = 1 -> hi_fwd = 3 and lo_fwd = 4 that cycle; next cycle super_sel = 2 gives wd = 3, super_sel = 3 gives wd = 4.
- Edge cases: rf_waW = 0 with we_regW = 1 -> rf_we = 0. valid_w = 0 -> no count, no HI/LO change. retired preset to 0xFFFFFFFF plus one valid instruction -> 0.
